input_pipeline_dma: RTL and testbench

Parametrised successor to the input pipeline stage. It is a start/done block-copy engine that streams a length-programmable run of words from a source 1R1W SRAM into a destination 1R1W SRAM, one word per cycle. On the way through it can byte-swap each word or stop at a zero terminator word. It sits between the preload memory (m1) and the working memory (m2), and later stages wait on its `done`.

---
 rtl/input_pipeline_pkg.sv | 18 +
 rtl/input_pipeline_dma_if.sv | 34 +++
 rtl/input_pipeline_dma_byte_swap.sv | 20 ++
 rtl/input_pipeline_dma.sv | 141 ++++++++++++++
 tb/tb_input_pipeline_dma.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/input_pipeline_pkg.sv
// input_pipeline_pkg
// Shared definitions for the input pipeline DMA stage: the engine state
// encoding and the job mode codes carried on the 2-bit `mode` input.
package input_pipeline_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Mode 3 is reserved and treated exactly like MODE_COPY.
    localparam logic [1:0] MODE_COPY  = 2'd0;
    localparam logic [1:0] MODE_BSWAP = 2'd1;
    localparam logic [1:0] MODE_ZTERM = 2'd2;

endpackage

// File: rtl/input_pipeline_dma_if.sv
// input_pipeline_dma_if
// SRAM bus between the DMA engine and its two 1R1W memories.
//   m1ReadAddr  : source read address (engine -> m1)
//   m1ReadVal   : source read data    (m1 -> engine)
//   m2WriteAddr : destination write address (engine -> m2)
//   m2WriteVal  : destination write data    (engine -> m2)
//   m2WE        : destination write enable  (engine -> m2)
// master = engine side, slave = memory side.
interface input_pipeline_dma_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] m1ReadAddr;
    logic [DATA_W-1:0] m1ReadVal;
    logic [ADDR_W-1:0] m2WriteAddr;
    logic [DATA_W-1:0] m2WriteVal;
    logic              m2WE;

    modport master (
        output m1ReadAddr,
        input  m1ReadVal,
        output m2WriteAddr,
        output m2WriteVal,
        output m2WE
    );

    modport slave (
        input  m1ReadAddr,
        output m1ReadVal,
        input  m2WriteAddr,
        input  m2WriteVal,
        input  m2WE
    );
endinterface

// File: rtl/input_pipeline_dma_byte_swap.sv
// byte_swap
// Combinational byte reversal of a DATA_W-bit word: output byte k is
// input byte (DATA_W/8 - 1 - k).
//   din  : input word
//   dout : byte-reversed word
module byte_swap #(
    parameter int unsigned DATA_W = 128
) (
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    localparam int unsigned NBYTES = DATA_W / 8;

    always_comb begin
        dout = '0;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            dout[8*k +: 8] = din[8*(NBYTES-1-k) +: 8];
        end
    end
endmodule

// File: rtl/input_pipeline_dma.sv
// input_pipeline_dma
// Start/done block-copy engine: streams `length` words from the source
// SRAM (m1) to the destination SRAM (m2), one word per cycle, optionally
// byte-swapping each word (mode 1) or stopping at a zero word (mode 2).
// Ports:
//   clock, rst_n   : clock, synchronous active-low reset
//   start          : level; launches a job when high in IDLE
//   hold           : suppresses new source reads while high
//   mode           : 0 copy, 1 byte-swap, 2 zero-terminated, 3 = copy
//   src_base, dst_base, length : job parameters, latched at launch
//   mem            : SRAM bus (master side), see input_pipeline_dma_if
//   busy           : high in RUN and DRAIN
//   done           : high in DONE
//   write_cnt      : words written in the current or last job
// The first read is issued on the launch edge itself. Read data for a
// registered m1ReadAddr is sampled on the following edge and written out
// (registered) on that edge.
module input_pipeline_dma
    import input_pipeline_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = ADDR_W + 1
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 hold,
    input  logic [1:0]           mode,
    input  logic [ADDR_W-1:0]    src_base,
    input  logic [ADDR_W-1:0]    dst_base,
    input  logic [CNT_W-1:0]     length,
    input_pipeline_dma_if.master mem,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     write_cnt
);
    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  rd_idx;
    logic [1:0]        mode_q;
    logic              in_flight;

    logic              launch;
    logic              term;
    logic              issue;
    logic              last_issue;
    logic [CNT_W-1:0]  rd_base;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] swapped;
    logic [DATA_W-1:0] wr_word;

    byte_swap #(.DATA_W(DATA_W)) u_byte_swap (
        .din  (mem.m1ReadVal),
        .dout (swapped)
    );

    // On the launch edge the job parameters come straight from the ports,
    // so the first read can go out without waiting for the latches.
    always_comb begin
        launch     = (state == ST_IDLE) && start;
        term       = in_flight && (mode_q == MODE_ZTERM) && (mem.m1ReadVal == '0);
        issue      = !hold && !term &&
                     ((state == ST_RUN) || (launch && (length != '0)));
        rd_base    = launch ? '0 : rd_idx;
        rd_addr    = launch ? src_base : src_q + ADDR_W'(rd_idx);
        last_issue = (rd_base + CNT_W'(1)) == (launch ? length : len_q);
        wr_word    = (mode_q == MODE_BSWAP) ? swapped : mem.m1ReadVal;
        busy       = (state == ST_RUN) || (state == ST_DRAIN);
        done       = (state == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            src_q           <= '0;
            dst_q           <= '0;
            len_q           <= '0;
            rd_idx          <= '0;
            mode_q          <= '0;
            in_flight       <= 1'b0;
            write_cnt       <= '0;
            mem.m1ReadAddr  <= '0;
            mem.m2WriteAddr <= '0;
            mem.m2WriteVal  <= '0;
            mem.m2WE        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        src_q     <= src_base;
                        dst_q     <= dst_base;
                        len_q     <= length;
                        mode_q    <= mode;
                        rd_idx    <= '0;
                        write_cnt <= '0;
                        if (length == '0)
                            state <= ST_DONE;
                        else if (issue && last_issue)
                            state <= ST_DRAIN;
                        else
                            state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (term)
                        state <= ST_DONE;
                    else if (issue && last_issue)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (term || !in_flight)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!start)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // A zero-terminated stop also blocks this cycle's issue, so no
            // further word is ever in flight after the terminator.
            in_flight <= issue;
            if (issue) begin
                mem.m1ReadAddr <= rd_addr;
                rd_idx         <= rd_base + CNT_W'(1);
            end

            mem.m2WE <= 1'b0;
            if (in_flight && !term) begin
                mem.m2WE        <= 1'b1;
                mem.m2WriteAddr <= dst_q + ADDR_W'(write_cnt);
                mem.m2WriteVal  <= wr_word;
                write_cnt       <= write_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_input_pipeline_dma.sv
module tb_input_pipeline_dma;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 17;

    logic              clock = 1'b0;
    logic              rst_n;
    logic              start;
    logic              hold;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [CNT_W-1:0]  length;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  write_cnt;

    input_pipeline_dma_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

    input_pipeline_dma #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .start     (start),
        .hold      (hold),
        .mode      (mode),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .length    (length),
        .mem       (mem_if),
        .busy      (busy),
        .done      (done),
        .write_cnt (write_cnt)
    );

    always #5 clock = ~clock;

    // Source and destination SRAMs.
    logic [DATA_W-1:0] m1     [65536];
    logic [DATA_W-1:0] m2     [65536];
    logic [DATA_W-1:0] exp_m2 [65536];

    assign mem_if.m1ReadVal = m1[mem_if.m1ReadAddr];

    always @(posedge clock) begin
        if (mem_if.m2WE) m2[mem_if.m2WriteAddr] <= mem_if.m2WriteVal;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] bswap(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        for (int k = 0; k < DATA_W/8; k++) r[8*k +: 8] = w[8*(DATA_W/8-1-k) +: 8];
        return r;
    endfunction

    task automatic snapshot();
        for (int a = 0; a < 65536; a++) exp_m2[a] = m2[a];
    endtask

    task automatic check_mem(input string nm);
        int bad = 0;
        for (int a = 65535; a >= 0; a--) if (m2[a] !== exp_m2[a]) bad = a;
        check({nm, " mem"}, m2[bad], exp_m2[bad]);
    endtask

    // One job. Latency is counted in edges after the launch edge until done
    // is first seen (spec cycle number = edges + 1). exp_cnt/exp_done < 0
    // mean "use the reference model's answer".
    task automatic run_job(input logic [1:0] md, input logic [15:0] src, input logic [15:0] dst,
                           input int len, input int h_at, input int h_n,
                           input int exp_cnt, input int exp_done, input string nm);
        int mcnt = 0;
        int mdone = (len == 0) ? 0 : -1;
        int done_e = -1;
        int we_n = 0;
        bit both = 0;
        bit retrig = 0;
        // Reference: word i is issued on the i-th edge with hold low; its
        // write lands one edge later; done follows the last write by one
        // edge, or the zero-word issue by one edge.
        snapshot();
        for (int i = 0; i < len; i++) begin
            int t = (i < h_at) ? i : i + h_n;
            logic [DATA_W-1:0] w = m1[16'(src + 16'(i))];
            if (md == 2'd2 && w == '0) begin
                mdone = t + 1;
                break;
            end
            exp_m2[16'(dst + 16'(i))] = (md == 2'd1) ? bswap(w) : w;
            mcnt++;
            if (i == len - 1) mdone = t + 2;
        end
        if (exp_cnt < 0) exp_cnt = mcnt;
        if (exp_done < 0) exp_done = mdone;

        @(negedge clock);
        mode = md; src_base = src; dst_base = dst; length = CNT_W'(len);
        start = 1'b1;
        hold = (h_at <= 0) && (0 < h_at + h_n);
        for (int e = 0; e < len + h_n + 10 && done_e < 0; e++) begin
            @(posedge clock);
            @(negedge clock);
            if (mem_if.m2WE) we_n++;
            if (busy && done) both = 1;
            if (done) done_e = e;
            hold = (e + 1 >= h_at) && (e + 1 < h_at + h_n);
        end
        hold = 1'b0;
        check({nm, " done_latency"}, DATA_W'(done_e), DATA_W'(exp_done));
        check({nm, " m2WE_pulses"}, DATA_W'(we_n), DATA_W'(exp_cnt));
        check({nm, " write_cnt"}, DATA_W'(write_cnt), DATA_W'(exp_cnt));
        check({nm, " busy_and_done"}, DATA_W'(both), '0);
        check_mem(nm);
        // start still high: must not retrigger
        repeat (4) begin
            @(negedge clock);
            if (busy || !done || mem_if.m2WE) retrig = 1;
        end
        check({nm, " no_retrigger"}, DATA_W'(retrig), '0);
        start = 1'b0;
        @(negedge clock);
        check({nm, " idle_after"}, DATA_W'({busy, done}), '0);
    endtask

    typedef struct {
        logic [1:0]  md;
        logic [15:0] src;
        logic [15:0] dst;
        int          len;
        int          h_at;
        int          h_n;
        int          exp_cnt;
        int          exp_done;
        string       nm;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [DATA_W-1:0] bw;
        int wn;
        rst_n = 1'b0; start = 1'b0; hold = 1'b0; mode = '0;
        src_base = '0; dst_base = '0; length = '0;

        for (int a = 0; a < 65536; a++) begin
            m1[a] = {$urandom, $urandom, $urandom, $urandom} | DATA_W'(1);
            m2[a] = '0;
        end
        for (int i = 0; i < 8; i++) m1[i] = DATA_W'(i + 1);
        bw = 128'h000102030405060708090A0B0C0D0E0F;
        m1[16'h0020] = bw;
        m1[16'h0040] = 5; m1[16'h0041] = 6; m1[16'h0042] = 7;
        m1[16'h0043] = 0; m1[16'h0044] = 9;

        //                md    src       dst       len h_at h_n cnt done name
        tbl[0] = '{2'd0, 16'h0000, 16'h0100,  8, 0, 0,  8,  9, "copy8"};
        tbl[1] = '{2'd1, 16'h0020, 16'h0200,  1, 0, 0,  1,  2, "bswap1"};
        tbl[2] = '{2'd2, 16'h0040, 16'h0300, 16, 0, 0,  3,  4, "zterm"};
        tbl[3] = '{2'd0, 16'hFFFE, 16'h0400,  4, 0, 0,  4,  5, "wrap"};
        tbl[4] = '{2'd0, 16'hFFFE, 16'h0410,  4, 2, 3,  4,  8, "wrap_hold3"};
        tbl[5] = '{2'd0, 16'h0010, 16'h0420,  0, 0, 0,  0,  0, "len0"};
        tbl[6] = '{2'd3, 16'h0010, 16'h0500,  3, 0, 0,  3,  4, "mode3"};
        tbl[7] = '{2'd0, 16'h3000, 16'h0700,  2, 0, 2,  2,  5, "hold_launch"};
        tbl[8] = '{2'd2, 16'h1000, 16'h0900,  5, 0, 0,  5,  6, "zterm_nozero"};
        tbl[9] = '{2'd1, 16'h0050, 16'hFFFF,  3, 0, 0,  3,  4, "bswap_dstwrap"};

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset m1ReadAddr", DATA_W'(mem_if.m1ReadAddr), '0);
        check("reset m2 bus", DATA_W'({mem_if.m2WriteAddr, mem_if.m2WE}), '0);
        check("reset m2WriteVal", mem_if.m2WriteVal, '0);
        check("reset status", DATA_W'({busy, done, write_cnt}), '0);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++)
            run_job(tbl[v].md, tbl[v].src, tbl[v].dst, tbl[v].len, tbl[v].h_at,
                    tbl[v].h_n, tbl[v].exp_cnt, tbl[v].exp_done, tbl[v].nm);
        check("bswap word", m2[16'h0200], 128'h0F0E0D0C0B0A09080706050403020100);
        check("zterm untouched", m2[16'h0303], '0);

        // Reset when the 4th write of a 10-word job is on the bus.
        snapshot();
        for (int i = 0; i < 4; i++) exp_m2[16'h0600 + i] = m1[16'h2000 + i];
        @(negedge clock);
        mode = 2'd0; src_base = 16'h2000; dst_base = 16'h0600; length = 17'd10; start = 1'b1;
        wn = 0;
        for (int e = 0; e < 30 && wn < 4; e++) begin
            @(posedge clock);
            @(negedge clock);
            if (mem_if.m2WE) wn++;
        end
        check("midrst reached 4th write", DATA_W'(wn), DATA_W'(4));
        rst_n = 1'b0; start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("midrst m1ReadAddr", DATA_W'(mem_if.m1ReadAddr), '0);
        check("midrst m2 bus", DATA_W'({mem_if.m2WriteAddr, mem_if.m2WE}), '0);
        check("midrst m2WriteVal", mem_if.m2WriteVal, '0);
        check("midrst status", DATA_W'({busy, done, write_cnt}), '0);
        rst_n = 1'b1;
        @(negedge clock);
        check("midrst stays idle", DATA_W'({busy, done, mem_if.m2WE}), '0);
        check_mem("midrst");
        run_job(2'd0, 16'h0060, 16'h0800, 2, 0, 0, 2, 3, "after_reset");

        // Randomised jobs against the reference model.
        for (int r = 0; r < 12; r++) begin
            logic [1:0]  md  = 2'($urandom_range(3, 0));
            logic [15:0] src = 16'($urandom);
            logic [15:0] dst = 16'($urandom);
            int          len = $urandom_range(20, 0);
            int          hat = $urandom_range(len, 0);
            int          hn  = $urandom_range(3, 0);
            if (md == 2'd2 && len > 0 && $urandom_range(1, 0) == 1)
                m1[16'(src + 16'($urandom_range(len - 1, 0)))] = '0;
            run_job(md, src, dst, len, hat, hn, -1, -1, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
